// File: rtl/bananachine_pkg.sv
// Shared constants and helpers for the Bananachine memory-side blocks.
package bananachine_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Index width for a channel count; never narrower than one bit.
  function automatic int CH_IDX_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request vector to one-hot grant, round-robin or fixed priority,
// with the last_grant register that steers the round-robin search.
module rr_arbiter
  import bananachine_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           req,
  output logic [NUM_CH-1:0]           grant,
  output logic [CH_IDX_W(NUM_CH)-1:0] grant_idx,
  output logic                        grant_any
);

  localparam int IW = CH_IDX_W(NUM_CH);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] start;
  logic [IW-1:0] cand;

  assign start = (last_grant == IW'(NUM_CH - 1)) ? '0 : last_grant + 1'b1;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == ARB_FIXED) cand = IW'(k);
      else                       cand = IW'((32'(start) + k) % 32'(NUM_CH));
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         last_grant <= IW'(NUM_CH - 1);
    else if (grant_any) last_grant <= grant_idx;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel front end for the single-port data memory: grants one
// requestor per cycle and routes load data back by a latency-matched tag pipe.
module mem_arbiter
  import bananachine_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_CH       = 3,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = ARB_RR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*WIDTH-1:0]      req_wdata,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic [WIDTH-1:0]             rsp_rdata,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [WIDTH-1:0]             mem_wdata,
  output logic                         mem_we,
  output logic                         mem_re,
  input  logic [WIDTH-1:0]             mem_rdata
);

  localparam int IW = CH_IDX_W(NUM_CH);

  logic [NUM_CH-1:0]       grant;
  logic [IW-1:0]           grant_idx;
  logic                    grant_any;
  logic [IW-1:0]           tag_idx [READ_LATENCY];
  logic [READ_LATENCY-1:0] tag_vld;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // grant_idx is zero when idle, so the address/data muxes fall back to channel 0.
  always_comb begin
    mem_addr  = req_addr[0 +: ADDR_WIDTH];
    mem_wdata = req_wdata[0 +: WIDTH];
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_idx == IW'(i)) begin
        mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign mem_we = grant_any &  req_write[grant_idx];
  assign mem_re = grant_any & ~req_write[grant_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= mem_re;
      tag_idx[0] <= grant_idx;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      rsp_valid[i] = tag_vld[READ_LATENCY-1] && (tag_idx[READ_LATENCY-1] == IW'(i));
  end

  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiter configurations share one request bus, each
// backed by its own write-first memory model with matching read latency.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_write = '0;
  logic [47:0] req_addr  = '0;
  logic [47:0] req_wdata = '0;

  logic [2:0]  a_ready, a_rsp, b_ready, b_rsp, c_ready, c_rsp;
  logic [15:0] a_rdata, a_addr, a_wdata, a_mrdata;
  logic [15:0] b_rdata, b_addr, b_wdata, b_mrdata;
  logic [15:0] c_rdata, c_addr, c_wdata, c_mrdata;
  logic        a_we, a_re, b_we, b_re, c_we, c_re;

  logic [15:0] ma [0:255];
  logic [15:0] mb [0:255];
  logic [15:0] mc [0:255];
  logic [15:0] a_p0, a_p1, b_p0, c_p0, c_p1, c_p2;

  int checks = 0;
  int errors = 0;

  logic [15:0] rr_data [3] = '{16'h1110, 16'h2220, 16'h3330};
  logic [2:0]  exp_g;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .NUM_CH(3), .READ_LATENCY(2), .ARB_MODE(0)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_ready), .rsp_valid(a_rsp),
    .rsp_rdata(a_rdata), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we),
    .mem_re(a_re), .mem_rdata(a_mrdata));

  mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .NUM_CH(3), .READ_LATENCY(1), .ARB_MODE(1)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_ready), .rsp_valid(b_rsp),
    .rsp_rdata(b_rdata), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we),
    .mem_re(b_re), .mem_rdata(b_mrdata));

  mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .NUM_CH(3), .READ_LATENCY(3), .ARB_MODE(0)) u_c (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(c_ready), .rsp_valid(c_rsp),
    .rsp_rdata(c_rdata), .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_we(c_we),
    .mem_re(c_re), .mem_rdata(c_mrdata));

  // Write-first memories: a read on the edge after a write sees the new word.
  always @(posedge clk) begin
    if (a_we) ma[a_addr[7:0]] <= a_wdata;
    if (b_we) mb[b_addr[7:0]] <= b_wdata;
    if (c_we) mc[c_addr[7:0]] <= c_wdata;
    a_p0 <= ma[a_addr[7:0]];  a_p1 <= a_p0;
    b_p0 <= mb[b_addr[7:0]];
    c_p0 <= mc[c_addr[7:0]];  c_p1 <= c_p0;  c_p2 <= c_p1;
  end
  assign a_mrdata = a_p1;
  assign b_mrdata = b_p0;
  assign c_mrdata = c_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
    req_valid[ch] = v;
    req_write[ch] = w;
    req_addr[ch*16 +: 16]  = a;
    req_wdata[ch*16 +: 16] = d;
  endtask

  initial begin
    ma[8'h10] = 16'hBEEF; mb[8'h10] = 16'hBEEF; mc[8'h10] = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      ma[8'h20 + i] = rr_data[i];
      mb[8'h20 + i] = rr_data[i];
      mc[8'h20 + i] = rr_data[i];
    end

    // Reset state
    tick; tick;
    chk("rst_a_ready", a_ready, 3'b000);
    chk("rst_a_rsp",   a_rsp,   3'b000);
    chk("rst_a_we",    a_we,    1'b0);
    chk("rst_a_re",    a_re,    1'b0);
    chk("rst_c_rsp",   c_rsp,   3'b000);
    reset = 1'b1;

    // Lone load from channel 1, latency 2 (and 1 on the fixed-priority instance)
    set_ch(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    chk("ld1_ready", a_ready, 3'b010);
    chk("ld1_re",    a_re,    1'b1);
    chk("ld1_addr",  a_addr,  16'h0010);
    tick;
    req_valid = '0;
    #1;
    chk("ld1_rsp_early", a_rsp,   3'b000);
    chk("ld1_b_rsp",     b_rsp,   3'b010);
    chk("ld1_b_rdata",   b_rdata, 16'hBEEF);
    tick;
    #1;
    chk("ld1_rsp",   a_rsp,   3'b010);
    chk("ld1_rdata", a_rdata, 16'hBEEF);
    tick;
    #1;
    chk("ld1_rsp_once", a_rsp, 3'b000);

    // Round-robin with all channels loading continuously
    tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) set_ch(i, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'h0000);
    for (int k = 0; k < 8; k++) begin
      if (k == 6) req_valid = '0;
      #1;
      exp_g = (k < 6) ? (3'b001 << (k % 3)) : 3'b000;
      chk("rr_ready",   a_ready, exp_g);
      chk("rr_c_ready", c_ready, exp_g);
      if (k >= 2) begin
        exp_g = 3'b001 << ((k - 2) % 3);
        chk("rr_rsp",   a_rsp,   exp_g);
        chk("rr_rdata", a_rdata, rr_data[(k - 2) % 3]);
      end
      tick;
    end

    // Fixed priority: channel 0 always wins
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fix_ready", b_ready, 3'b001);
      if (k >= 1) begin
        chk("fix_rsp",   b_rsp,   3'b001);
        chk("fix_rdata", b_rdata, 16'h1110);
      end
      tick;
    end
    req_valid = '0;
    repeat (4) tick;

    // Store then load to the same address on the next cycle
    set_ch(0, 1'b1, 1'b1, 16'h0040, 16'h1234);
    #1;
    chk("st_ready", a_ready, 3'b001);
    chk("st_we",    a_we,    1'b1);
    chk("st_re",    a_re,    1'b0);
    chk("st_addr",  a_addr,  16'h0040);
    chk("st_wdata", a_wdata, 16'h1234);
    tick;
    set_ch(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_ch(2, 1'b1, 1'b0, 16'h0040, 16'h0000);
    #1;
    chk("raw_ready", a_ready, 3'b100);
    chk("raw_re",    a_re,    1'b1);
    chk("raw_rsp0",  a_rsp,   3'b000);
    tick;
    req_valid = '0;
    #1;
    chk("st_no_rsp",   a_rsp,   3'b000);
    chk("raw_b_rsp",   b_rsp,   3'b100);
    chk("raw_b_rdata", b_rdata, 16'h1234);
    tick;
    #1;
    chk("raw_rsp",   a_rsp,   3'b100);
    chk("raw_rdata", a_rdata, 16'h1234);
    tick;
    tick;

    // Reset with two loads in flight at latency 3
    set_ch(2, 1'b1, 1'b0, 16'h0022, 16'h0000);
    #1;
    chk("fl_ready2", c_ready, 3'b100);
    tick;
    set_ch(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_ch(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    #1;
    chk("fl_ready0", c_ready, 3'b001);
    tick;
    req_valid = '0;
    reset = 1'b0;
    #1;
    chk("fl_rst_rsp",   c_rsp,   3'b000);
    chk("fl_rst_ready", c_ready, 3'b000);
    tick;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fl_no_rsp", c_rsp, 3'b000);
      tick;
    end
    for (int i = 0; i < 3; i++) set_ch(i, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'h0000);
    #1;
    chk("fl_first_grant",   c_ready, 3'b001);
    chk("fl_a_first_grant", a_ready, 3'b001);
    tick;
    req_valid = '0;

    // Idle cycles leave last_grant alone
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("idle_we",    a_we,    1'b0);
      chk("idle_re",    a_re,    1'b0);
      chk("idle_ready", a_ready, 3'b000);
      tick;
    end
    req_valid = 3'b111;
    #1;
    chk("idle_next_grant", a_ready, 3'b010);
    chk("idle_fix_grant",  b_ready, 3'b001);
    tick;
    req_valid = '0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised multi-channel front end for the single-port data memory in the Bananachine CPU/memory top level. Replaces the point-to-point CPU-to-memory port wiring. NUM_CH requestors (CPU data load/store, CPU fetch, future DMA/video) share one memory port. Grants are issued by round-robin or fixed priority, and read data is routed back to the issuing channel after a configurable memory read latency.

## Interface
- WIDTH, 16, data word width
- ADDR_WIDTH, 16, address width
- NUM_CH, 3, requestor channel count (2..8)
- READ_LATENCY, 1, cycles from memory read strobe to valid mem_rdata (1..4)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clk  in  1  system clock; all state is on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  NUM_CH  per-channel request
- req_write  in  NUM_CH  1 = store, 0 = load
- req_addr  in  NUM_CH*ADDR_WIDTH  packed addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_CH*WIDTH  packed store data
- req_ready  out  NUM_CH  one-hot grant; the request is accepted this cycle
- rsp_valid  out  NUM_CH  one-hot read-data-valid pulse
- rsp_rdata  out  WIDTH  read data, shared by all channels; qualified by rsp_valid
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  WIDTH  memory read data, valid READ_LATENCY cycles after mem_re

## Operation
- Acceptance: a transfer happens when req_valid[i] and req_ready[i] are both high. A requestor holds valid, write, addr and wdata stable until it is accepted.
- Grants: at most one per cycle. req_ready is combinational from req_valid and the arbiter state. No grant when no channel is valid.
- Round-robin: search starts at last_grant+1 modulo NUM_CH. last_grant updates only on a grant.
- Fixed priority: lowest-index valid channel wins; last_grant is ignored.
- Memory side: mem_addr, mem_wdata, mem_we and mem_re are combinational muxes of the granted channel.
  - mem_we = grant & write.
  - mem_re = grant & !write.
  - With no grant: mem_we = mem_re = 0, and mem_addr/mem_wdata hold the value from channel 0.
- Stores complete at acceptance and produce no response.
- Loads: the channel index and a valid bit enter a READ_LATENCY-deep tag shift register.
  - When a tag reaches the end with valid set, rsp_valid[tag] = 1 for one cycle and rsp_rdata = mem_rdata.
  - rsp_rdata passes mem_rdata through when no response is valid.
- A channel may have up to READ_LATENCY loads in flight. Responses return in issue order. There is no response backpressure; a requestor must sink every pulse.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid is produced for them. The memory array contents are not affected.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, mem_we = 0, mem_re = 0.
  - last_grant = NUM_CH-1, so channel 0 wins first after reset.
  - Tag pipe all invalid.
- Grant latency is 0 cycles: a lone valid request is accepted in the cycle it is presented.
- Load latency: rsp_valid is high exactly READ_LATENCY cycles after the accepting edge.
- Throughput is one access per cycle, with back-to-back loads from any mix of channels.
- Load and store on the same cycle cannot occur because there is a single grant.
- A store followed by a load to the same address on the next cycle returns the new data; this relies on memory write-first behaviour.
- Simultaneous response and new grant to the same channel are both legal in one cycle.

## Structure
- Shared package bananachine_pkg holds ARB_RR = 0, ARB_FIXED = 1, and a clog2-based CH_IDX_W function.
- Sub-module rr_arbiter (parameters NUM_CH and ARB_MODE) contains the request vector → one-hot grant logic and the last_grant register.
- Tag pipe and muxes stay in mem_arbiter.
- In the top level, mem_arbiter sits between the CPU and basic_mem port b.

## Test plan
- Reset, then channel 1 loads address 0x0010 holding 0xBEEF with READ_LATENCY = 2. Required: req_ready[1] high in the same cycle, and rsp_valid = 3'b010 with rdata 0xBEEF two cycles later.
- All three channels hold loads continuously in round-robin mode. Required: grant order 0, 1, 2, 0, 1, 2; responses arrive in the same order, one per cycle.
- ARB_MODE = 1, all channels valid for 4 cycles. Required: only channel 0 is granted, and channels 1 and 2 see ready = 0 throughout.
- Channel 0 stores 0x1234 to 0x0040, then channel 2 loads 0x0040 on the next cycle. Required: channel 2 receives 0x1234, and no rsp_valid is produced for the store.
- Two loads are in flight with READ_LATENCY = 3 and reset is pulled low for 1 cycle. Required: no rsp_valid afterwards, and the first grant after release goes to channel 0.
- No requests for 5 cycles. Required: mem_we = mem_re = 0, req_ready = 0, and last_grant unchanged.
